// File: rtl/qsfp_i2c_cmd_seq.sv
// ============================================================================
//  Module      : qsfp_i2c_cmd_seq
//  Description : Issues the register accesses for one QSFP I2C byte
//                transaction per start pulse toward a simple TG-style
//                AXI-lite master: program address (and data on writes),
//                kick control, poll the done bit, fetch read data.
//                POLL_GAP must be at least 1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qsfp_i2c_cmd_seq #(
    parameter int unsigned                AXI_ADDR_WIDTH = 32,
    parameter int unsigned                AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0]  CTRL_OFS       = 'h00,
    parameter logic [AXI_ADDR_WIDTH-1:0]  ADDR_OFS       = 'h04,
    parameter logic [AXI_ADDR_WIDTH-1:0]  WDATA_OFS      = 'h08,
    parameter logic [AXI_ADDR_WIDTH-1:0]  RDATA_OFS      = 'h0C,
    parameter int unsigned                POLL_GAP       = 5000,
    parameter int unsigned                POLL_MAX       = 1024,
    parameter int unsigned                ACK_TIMEOUT    = 4096
) (
    input  logic                          m_axi_aclk,
    input  logic                          m_axi_areset,
    input  logic                          start,
    input  logic                          cmd_rw,
    input  logic [7:0]                    cmd_dev_id,
    input  logic [7:0]                    cmd_reg,
    input  logic [7:0]                    cmd_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [7:0]                    rd_byte,
    output logic                          wr_req,
    output logic                          rd_req,
    output logic [AXI_ADDR_WIDTH-1:0]     addr,
    output logic [AXI_DATA_WIDTH-1:0]     wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   wstrb,
    input  logic                          op_ack,
    input  logic [AXI_DATA_WIDTH-1:0]     rdata
);

    localparam int unsigned c_ACK_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned c_GAP_W  = $clog2(POLL_GAP + 1);
    localparam int unsigned c_POLL_W = $clog2(POLL_MAX + 1);

    localparam logic [c_ACK_W-1:0]  c_ACK_MAX  = c_ACK_W'(ACK_TIMEOUT);
    localparam logic [c_ACK_W-1:0]  c_ACK_LAST = c_ACK_W'(ACK_TIMEOUT - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_MAX  = c_GAP_W'(POLL_GAP);
    localparam logic [c_GAP_W-1:0]  c_GAP_LAST = c_GAP_W'(POLL_GAP - 1);
    localparam logic [c_POLL_W-1:0] c_POLL_MAX = c_POLL_W'(POLL_MAX);

    localparam logic [3:0] c_ST_IDLE   = 4'd0;
    localparam logic [3:0] c_ST_W_ADDR = 4'd1;
    localparam logic [3:0] c_ST_W_DATA = 4'd2;
    localparam logic [3:0] c_ST_W_CTRL = 4'd3;
    localparam logic [3:0] c_ST_POLL   = 4'd4;
    localparam logic [3:0] c_ST_GAP    = 4'd5;
    localparam logic [3:0] c_ST_R_DATA = 4'd6;
    localparam logic [3:0] c_ST_FIN    = 4'd7;
    localparam logic [3:0] c_ST_ERR    = 4'd8;

    logic [3:0]                r_state;
    logic [3:0]                w_next;
    logic                      r_cmd_rw;
    logic [7:0]                r_cmd_dev_id;
    logic [7:0]                r_cmd_wdata;
    logic [c_ACK_W-1:0]        r_ack_cnt;
    logic [c_GAP_W-1:0]        r_gap_cnt;
    logic [c_POLL_W-1:0]       r_poll_cnt;
    logic [c_POLL_W-1:0]       w_poll_inc;
    logic                      r_wr_req;
    logic                      r_rd_req;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] r_wstrb;
    logic [7:0]                r_rd_byte;
    logic [AXI_DATA_WIDTH-1:0] w_ctrl_word;
    logic                      w_in_access;
    logic                      w_ack;
    logic                      w_ack_expired;
    logic                      w_busy;
    logic                      w_done;
    logic                      w_err;
    logic                      w_rdata_unused;

    // Only the done bit and the low byte of rdata carry meaning here
    assign w_rdata_unused = ^{rdata[AXI_DATA_WIDTH-1:31], rdata[29:8]};

    // An ack landing in the request cycle cannot belong to this access
    assign w_in_access   = (r_state == c_ST_W_ADDR) || (r_state == c_ST_W_DATA) ||
                           (r_state == c_ST_W_CTRL) || (r_state == c_ST_POLL)   ||
                           (r_state == c_ST_R_DATA);
    assign w_ack         = op_ack && w_in_access && !(r_wr_req || r_rd_req);
    assign w_ack_expired = w_in_access && !w_ack && (r_ack_cnt == c_ACK_LAST);
    assign w_poll_inc    = (r_poll_cnt == c_POLL_MAX) ? r_poll_cnt : r_poll_cnt + 1'b1;

    // Control register image: rw in bit 31, device ID in the low byte
    always_comb begin
        w_ctrl_word      = '0;
        w_ctrl_word[31]  = r_cmd_rw;
        w_ctrl_word[7:0] = r_cmd_dev_id;
    end

    // State register
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode for the transaction sequence
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_next = c_ST_W_ADDR;
            end
            c_ST_W_ADDR: begin
                if (w_ack)              w_next = r_cmd_rw ? c_ST_W_CTRL : c_ST_W_DATA;
                else if (w_ack_expired) w_next = c_ST_ERR;
            end
            c_ST_W_DATA: begin
                if (w_ack)              w_next = c_ST_W_CTRL;
                else if (w_ack_expired) w_next = c_ST_ERR;
            end
            c_ST_W_CTRL: begin
                if (w_ack)              w_next = c_ST_POLL;
                else if (w_ack_expired) w_next = c_ST_ERR;
            end
            c_ST_POLL: begin
                if (w_ack) begin
                    if (rdata[30])                     w_next = r_cmd_rw ? c_ST_R_DATA : c_ST_FIN;
                    else if (w_poll_inc == c_POLL_MAX) w_next = c_ST_ERR;
                    else                               w_next = c_ST_GAP;
                end else if (w_ack_expired) begin
                    w_next = c_ST_ERR;
                end
            end
            c_ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) w_next = c_ST_POLL;
            end
            c_ST_R_DATA: begin
                if (w_ack)              w_next = c_ST_FIN;
                else if (w_ack_expired) w_next = c_ST_ERR;
            end
            c_ST_FIN: w_next = c_ST_IDLE;
            c_ST_ERR: w_next = c_ST_IDLE;
            default:  w_next = c_ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        w_err  = 1'b0;
        case (r_state)
            c_ST_IDLE: ;
            c_ST_FIN:  w_done = 1'b1;
            c_ST_ERR:  w_err  = 1'b1;
            default:   w_busy = 1'b1;
        endcase
    end

    // Request pulse and bus fields are loaded on entry to each access state
    // so they are valid in the request cycle and held until the next access
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_wr_req     <= 1'b0;
            r_rd_req     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rd_byte    <= '0;
            r_cmd_rw     <= 1'b0;
            r_cmd_dev_id <= '0;
            r_cmd_wdata  <= '0;
        end else begin
            r_wr_req <= 1'b0;
            r_rd_req <= 1'b0;
            if (r_state == c_ST_IDLE && start) begin
                r_cmd_rw     <= cmd_rw;
                r_cmd_dev_id <= cmd_dev_id;
                r_cmd_wdata  <= cmd_wdata;
            end
            if (w_next != r_state) begin
                case (w_next)
                    c_ST_W_ADDR: begin
                        r_wr_req <= 1'b1;
                        r_addr   <= ADDR_OFS;
                        r_wdata  <= AXI_DATA_WIDTH'(cmd_reg);
                        r_wstrb  <= '1;
                    end
                    c_ST_W_DATA: begin
                        r_wr_req <= 1'b1;
                        r_addr   <= WDATA_OFS;
                        r_wdata  <= AXI_DATA_WIDTH'(r_cmd_wdata);
                        r_wstrb  <= '1;
                    end
                    c_ST_W_CTRL: begin
                        r_wr_req <= 1'b1;
                        r_addr   <= CTRL_OFS;
                        r_wdata  <= w_ctrl_word;
                        r_wstrb  <= '1;
                    end
                    c_ST_POLL: begin
                        r_rd_req <= 1'b1;
                        r_addr   <= CTRL_OFS;
                        r_wstrb  <= '0;
                    end
                    c_ST_R_DATA: begin
                        r_rd_req <= 1'b1;
                        r_addr   <= RDATA_OFS;
                        r_wstrb  <= '0;
                    end
                    default: ;
                endcase
            end
            if (r_state == c_ST_R_DATA && w_ack) begin
                r_rd_byte <= rdata[7:0];
            end
        end
    end

    // Ack-wait, gap and poll counters; ack/gap restart on every state change
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            r_ack_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_poll_cnt <= '0;
        end else begin
            if (w_next != r_state) begin
                r_ack_cnt <= '0;
            end else if (w_in_access && r_ack_cnt != c_ACK_MAX) begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end

            if (w_next != r_state) begin
                r_gap_cnt <= '0;
            end else if (r_state == c_ST_GAP && r_gap_cnt != c_GAP_MAX) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end

            if (r_state == c_ST_IDLE && start) begin
                r_poll_cnt <= '0;
            end else if (r_state == c_ST_POLL && w_ack) begin
                r_poll_cnt <= w_poll_inc;
            end
        end
    end

    assign busy    = w_busy;
    assign done    = w_done;
    assign err     = w_err;
    assign rd_byte = r_rd_byte;
    assign wr_req  = r_wr_req;
    assign rd_req  = r_rd_req;
    assign addr    = r_addr;
    assign wdata   = r_wdata;
    assign wstrb   = r_wstrb;

endmodule

`default_nettype wire

// File: tb/tb_qsfp_i2c_cmd_seq.sv
// ============================================================================
//  Module      : tb_qsfp_i2c_cmd_seq
//  Description : Directed bench for qsfp_i2c_cmd_seq with a behavioural
//                register-file responder that logs every access.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qsfp_i2c_cmd_seq;

    localparam int unsigned c_GAP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cmd_rw = 1'b0;
    logic [7:0]  cmd_dev_id = '0;
    logic [7:0]  cmd_reg = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        busy, done, err;
    logic [7:0]  rd_byte;
    logic        wr_req, rd_req;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        op_ack = 1'b0;
    logic [31:0] rdata = '0;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // responder configuration (written by the stimulus process)
    int          lat = 1;
    int          done_on = 1;
    logic        no_ack = 1'b0;
    logic [7:0]  rd_val = 8'h00;
    int          poll_base = 0;

    // responder state and access log (written by the responder only)
    int          poll_idx = 0;
    logic        pending = 1'b0;
    int          acnt = 0;
    int          both_cnt = 0;
    int          overlap_cnt = 0;
    int          log_n = 0;
    logic [68:0] log_ent [128];
    int          log_cyc [128];

    qsfp_i2c_cmd_seq #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .POLL_GAP       (c_GAP),
        .POLL_MAX       (4),
        .ACK_TIMEOUT    (16)
    ) dut (
        .m_axi_aclk   (clk),
        .m_axi_areset (rst),
        .start        (start),
        .cmd_rw       (cmd_rw),
        .cmd_dev_id   (cmd_dev_id),
        .cmd_reg      (cmd_reg),
        .cmd_wdata    (cmd_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .rd_byte      (rd_byte),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .addr         (addr),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .op_ack       (op_ack),
        .rdata        (rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-file responder: logs requests, acks after lat cycles
    always @(negedge clk) begin
        op_ack = 1'b0;
        if (rst) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                acnt = acnt - 1;
                if (acnt <= 0) begin
                    op_ack  = 1'b1;
                    pending = 1'b0;
                end
            end
            if (wr_req && rd_req) both_cnt = both_cnt + 1;
            if (wr_req || rd_req) begin
                if (pending) overlap_cnt = overlap_cnt + 1;
                if (log_n < 128) begin
                    log_ent[log_n] = {wr_req, addr, (wr_req ? wdata : 32'h0), wstrb};
                    log_cyc[log_n] = cyc;
                    log_n = log_n + 1;
                end
                if (rd_req && addr == 32'h0) begin
                    poll_idx = poll_idx + 1;
                    rdata = ((poll_idx - poll_base) >= done_on) ? 32'h4000_00A5 : 32'h0000_00A5;
                end else if (rd_req && addr == 32'h0C) begin
                    rdata = {24'hABCDEF, rd_val};
                end else begin
                    rdata = 32'h0;
                end
                if (!no_ack) begin
                    pending = 1'b1;
                    acnt    = lat;
                end
            end
        end
    end

    task automatic do_start(input logic rw, input logic [7:0] dev, input logic [7:0] rg,
                            input logic [7:0] wd);
        @(posedge clk); #1;
        start = 1'b1; cmd_rw = rw; cmd_dev_id = dev; cmd_reg = rg; cmd_wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int limit, output logic got_done, output logic got_err,
                            output logic busy_at, output int at_cyc);
        got_done = 1'b0; got_err = 1'b0; busy_at = 1'b1; at_cyc = -1;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (done || err) begin
                got_done = done; got_err = err; busy_at = busy; at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++; if ({busy, done, err} !== 3'b000) begin n_err++; $display("FAIL reset_status got=%b exp=000", {busy, done, err}); end
        n_vec++; if ({wr_req, rd_req} !== 2'b00) begin n_err++; $display("FAIL reset_req got=%b exp=00", {wr_req, rd_req}); end
        n_vec++; if (rd_byte !== 8'h00) begin n_err++; $display("FAIL reset_rd_byte got=%h exp=00", rd_byte); end
        n_vec++; if ({addr, wdata, wstrb} !== 68'h0) begin n_err++; $display("FAIL reset_bus got=%h/%h/%h exp=0", addr, wdata, wstrb); end
    endtask

    task automatic test_write();
        logic [68:0] exp [6];
        logic gd, ge, ba; int ac; int b;
        exp[0] = {1'b1, 32'h04, 32'h01, 4'hF};
        exp[1] = {1'b1, 32'h08, 32'hAA, 4'hF};
        exp[2] = {1'b1, 32'h00, 32'h42, 4'hF};
        exp[3] = {1'b0, 32'h00, 32'h00, 4'h0};
        exp[4] = exp[3];
        exp[5] = exp[3];
        lat = 2; done_on = 3; poll_base = poll_idx; b = log_n;
        do_start(1'b0, 8'h42, 8'h01, 8'hAA);
        wait_end(500, gd, ge, ba, ac);
        n_vec++; if ({gd, ge} !== 2'b10) begin n_err++; $display("FAIL wr_done_err got=%b exp=10", {gd, ge}); end
        n_vec++; if (ba !== 1'b0) begin n_err++; $display("FAIL wr_busy_at_done got=%b exp=0", ba); end
        n_vec++; if (log_n - b !== 6) begin n_err++; $display("FAIL wr_access_count got=%0d exp=6", log_n - b); end
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (log_ent[b+i] !== exp[i]) begin n_err++; $display("FAIL wr_access%0d got=%h exp=%h", i, log_ent[b+i], exp[i]); end
        end
        n_vec++; if (log_cyc[b+3] - log_cyc[b+2] !== lat + 1) begin n_err++; $display("FAIL wr_first_poll_spacing got=%0d exp=%0d", log_cyc[b+3] - log_cyc[b+2], lat + 1); end
        for (int i = 3; i < 5; i++) begin
            n_vec++; if (log_cyc[b+i+1] - log_cyc[b+i] < lat + 1 + c_GAP) begin n_err++; $display("FAIL wr_poll_gap%0d got=%0d exp>=%0d", i, log_cyc[b+i+1] - log_cyc[b+i], lat + 1 + c_GAP); end
        end
        n_vec++; if (rd_byte !== 8'h00) begin n_err++; $display("FAIL wr_rd_byte got=%h exp=00", rd_byte); end
    endtask

    task automatic test_read();
        logic [68:0] exp [4];
        logic gd, ge, ba; int ac; int b;
        exp[0] = {1'b1, 32'h04, 32'h01, 4'hF};
        exp[1] = {1'b1, 32'h00, 32'h8000_0042, 4'hF};
        exp[2] = {1'b0, 32'h00, 32'h00, 4'h0};
        exp[3] = {1'b0, 32'h0C, 32'h00, 4'h0};
        lat = 1; done_on = 1; rd_val = 8'h5C; poll_base = poll_idx; b = log_n;
        do_start(1'b1, 8'h42, 8'h01, 8'hEE);
        wait_end(500, gd, ge, ba, ac);
        n_vec++; if ({gd, ge} !== 2'b10) begin n_err++; $display("FAIL rd_done_err got=%b exp=10", {gd, ge}); end
        n_vec++; if (log_n - b !== 4) begin n_err++; $display("FAIL rd_access_count got=%0d exp=4", log_n - b); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (log_ent[b+i] !== exp[i]) begin n_err++; $display("FAIL rd_access%0d got=%h exp=%h", i, log_ent[b+i], exp[i]); end
        end
        n_vec++; if (rd_byte !== 8'h5C) begin n_err++; $display("FAIL rd_rd_byte got=%h exp=5C", rd_byte); end
    endtask

    task automatic test_poll_timeout();
        logic gd, ge, ba; int ac; int b; int np;
        lat = 1; done_on = 100; rd_val = 8'h99; poll_base = poll_idx; b = log_n;
        do_start(1'b1, 8'h50, 8'h02, 8'h00);
        wait_end(500, gd, ge, ba, ac);
        n_vec++; if ({gd, ge} !== 2'b01) begin n_err++; $display("FAIL pto_done_err got=%b exp=01", {gd, ge}); end
        n_vec++; if (ba !== 1'b0) begin n_err++; $display("FAIL pto_busy_at_err got=%b exp=0", ba); end
        np = 0;
        for (int i = b; i < log_n; i++) if (log_ent[i] === {1'b0, 32'h00, 32'h00, 4'h0}) np++;
        n_vec++; if (np !== 4) begin n_err++; $display("FAIL pto_poll_count got=%0d exp=4", np); end
        n_vec++; if (log_n - b !== 6) begin n_err++; $display("FAIL pto_access_count got=%0d exp=6", log_n - b); end
        n_vec++; if (rd_byte !== 8'h5C) begin n_err++; $display("FAIL pto_rd_byte got=%h exp=5C", rd_byte); end
    endtask

    task automatic test_ack_timeout();
        logic gd, ge, ba; int ac; int b;
        no_ack = 1'b1; b = log_n;
        do_start(1'b0, 8'h11, 8'h22, 8'h33);
        wait_end(200, gd, ge, ba, ac);
        n_vec++; if ({gd, ge} !== 2'b01) begin n_err++; $display("FAIL ato_done_err got=%b exp=01", {gd, ge}); end
        n_vec++; if (ac !== log_cyc[b] + 16) begin n_err++; $display("FAIL ato_err_cycle got=%0d exp=%0d", ac, log_cyc[b] + 16); end
        repeat (20) @(posedge clk);
        #1;
        n_vec++; if (log_n - b !== 1) begin n_err++; $display("FAIL ato_access_count got=%0d exp=1", log_n - b); end
        no_ack = 1'b0;
    endtask

    task automatic test_busy_start();
        logic [68:0] exp [4];
        logic gd, ge, ba; int ac; int b;
        exp[0] = {1'b1, 32'h04, 32'h05, 4'hF};
        exp[1] = {1'b1, 32'h08, 32'h33, 4'hF};
        exp[2] = {1'b1, 32'h00, 32'h10, 4'hF};
        exp[3] = {1'b0, 32'h00, 32'h00, 4'h0};
        lat = 1; done_on = 1; poll_base = poll_idx; b = log_n;
        do_start(1'b0, 8'h10, 8'h05, 8'h33);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; cmd_rw = 1'b1; cmd_dev_id = 8'h7E; cmd_reg = 8'h77; cmd_wdata = 8'h66;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end(500, gd, ge, ba, ac);
        n_vec++; if ({gd, ge} !== 2'b10) begin n_err++; $display("FAIL bs_done_err got=%b exp=10", {gd, ge}); end
        n_vec++; if (log_n - b !== 4) begin n_err++; $display("FAIL bs_access_count got=%0d exp=4", log_n - b); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (log_ent[b+i] !== exp[i]) begin n_err++; $display("FAIL bs_access%0d got=%h exp=%h", i, log_ent[b+i], exp[i]); end
        end
        // start during the done cycle, then held into the following cycle
        start = 1'b1; cmd_rw = 1'b0; cmd_dev_id = 8'h10; cmd_reg = 8'h11; cmd_wdata = 8'h44;
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL bs_start_in_done_busy got=%b exp=0", busy); end
        cmd_reg = 8'h22;
        poll_base = poll_idx;
        @(posedge clk); #1;
        start = 1'b0;
        n_vec++; if ({busy, wr_req, addr, wdata} !== {1'b1, 1'b1, 32'h04, 32'h22}) begin n_err++; $display("FAIL bs_restart got=%b/%b/%h/%h exp=1/1/04/22", busy, wr_req, addr, wdata); end
        wait_end(500, gd, ge, ba, ac);
        n_vec++; if ({gd, ge} !== 2'b10) begin n_err++; $display("FAIL bs_restart_done got=%b exp=10", {gd, ge}); end
    endtask

    task automatic test_reset_gap();
        logic gd, ge, ba; int ac; int b; logic seen;
        lat = 1; done_on = 3; poll_base = poll_idx; b = log_n;
        do_start(1'b0, 8'h42, 8'h03, 8'h55);
        for (int i = 0; i < 200 && log_n < b + 4; i++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if ({busy, done, err, wr_req, rd_req} !== 5'b0) begin n_err++; $display("FAIL rg_status got=%b exp=00000", {busy, done, err, wr_req, rd_req}); end
        n_vec++; if ({addr, wdata, wstrb, rd_byte} !== 76'h0) begin n_err++; $display("FAIL rg_bus got=%h/%h/%h/%h exp=0", addr, wdata, wstrb, rd_byte); end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || err || busy) seen = 1'b1;
        end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rg_quiet got=%b exp=0", seen); end
        n_vec++; if (log_n - b !== 4) begin n_err++; $display("FAIL rg_access_count got=%0d exp=4", log_n - b); end
        done_on = 1; rd_val = 8'h3C; poll_base = poll_idx;
        do_start(1'b1, 8'h42, 8'h09, 8'h00);
        wait_end(500, gd, ge, ba, ac);
        n_vec++; if ({gd, ge} !== 2'b10) begin n_err++; $display("FAIL rg_after_done got=%b exp=10", {gd, ge}); end
        n_vec++; if (rd_byte !== 8'h3C) begin n_err++; $display("FAIL rg_after_rd_byte got=%h exp=3C", rd_byte); end
    endtask

    task automatic test_exclusive();
        n_vec++; if (both_cnt !== 0) begin n_err++; $display("FAIL excl_both_req got=%0d exp=0", both_cnt); end
        n_vec++; if (overlap_cnt !== 0) begin n_err++; $display("FAIL excl_outstanding got=%0d exp=0", overlap_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_poll_timeout();
        test_ack_timeout();
        test_busy_start();
        test_reset_gap();
        test_exclusive();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
